// File: rtl/sort_stream_io_if.sv
// Valid/ready byte stream used for both the load and unload sides of sort_stream_io.
// The master drives valid/data and the slave answers with ready.
interface sort_stream_io_if #(
  parameter int DW = 8
) ();
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sort_stream_io.sv
// Stream front/back end for the 8-entry RAM sort engine: load K words, start the sorter,
// then stream the sorted RAM contents out. A watchdog traps a sorter that never finishes.
module sort_stream_io #(
  parameter int K       = 8,
  parameter int AW      = 3,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  sort_stream_io_if.slave        in_s,
  sort_stream_io_if.master       out_s,
  output logic                   mem_sel,
  output logic                   ram_we,
  output logic [AW-1:0]          ram_addr,
  output logic [DW-1:0]          ram_din,
  input  logic [DW-1:0]          ram_dout,
  output logic                   sort_s,
  input  logic                   sort_done,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SORT   = 3'd2;
  localparam logic [2:0] S_UNLOAD = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  localparam int             WW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WW-1:0]  WD_LAST = WW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  // Counters carry one extra bit so K == 2**AW does not alias the last index with zero.
  localparam logic [AW:0]    LAST    = (AW+1)'(K - 1);

  logic [2:0]    state_reg, state_next;
  logic [AW:0]   wr_cnt_reg, wr_cnt_next;
  logic [AW:0]   rd_cnt_reg, rd_cnt_next;
  logic [WW-1:0] wdog_reg, wdog_next;
  logic          in_acc, out_acc, wdog_hit;

  assign in_acc   = (state_reg == S_LOAD) && in_s.valid;
  assign out_acc  = (state_reg == S_UNLOAD) && out_s.ready;
  assign wdog_hit = (TIMEOUT != 0) && (wdog_reg == WD_LAST);

  always_comb begin
    state_next  = state_reg;
    wr_cnt_next = wr_cnt_reg;
    rd_cnt_next = rd_cnt_reg;
    wdog_next   = '0;
    case (state_reg)
      S_IDLE: state_next = S_LOAD;
      S_LOAD: begin
        if (in_acc) begin
          if (wr_cnt_reg == LAST) begin
            wr_cnt_next = '0;
            state_next  = S_SORT;
          end else begin
            wr_cnt_next = wr_cnt_reg + 1'b1;
          end
        end
      end
      S_SORT: begin
        // done takes priority over a watchdog expiry in the same cycle
        if (sort_done) begin
          state_next = S_UNLOAD;
        end else if (wdog_hit) begin
          state_next = S_ERR;
        end else begin
          wdog_next = wdog_reg + 1'b1;
        end
      end
      S_UNLOAD: begin
        if (out_acc) begin
          if (rd_cnt_reg == LAST) begin
            rd_cnt_next = '0;
            state_next  = S_LOAD;
          end else begin
            rd_cnt_next = rd_cnt_reg + 1'b1;
          end
        end
      end
      S_ERR:   state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      wr_cnt_reg <= '0;
      rd_cnt_reg <= '0;
      wdog_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      wr_cnt_reg <= wr_cnt_next;
      rd_cnt_reg <= rd_cnt_next;
      wdog_reg   <= wdog_next;
    end
  end

  // Handshake outputs depend only on state; data paths pass through while their state is active.
  assign in_s.ready  = (state_reg == S_LOAD);
  assign out_s.valid = (state_reg == S_UNLOAD);
  assign out_s.data  = (state_reg == S_UNLOAD) ? ram_dout : '0;

  // Held low while reset is asserted so the RAM mux starts from a known owner.
  assign mem_sel    = rst && (state_reg != S_SORT);
  assign ram_we     = in_acc;
  assign ram_addr   = (state_reg == S_LOAD)   ? wr_cnt_reg[AW-1:0] :
                      (state_reg == S_UNLOAD) ? rd_cnt_reg[AW-1:0] : '0;
  assign ram_din    = (state_reg == S_LOAD) ? in_s.data : '0;
  assign sort_s     = (state_reg == S_SORT);
  assign busy       = (state_reg == S_SORT) || (state_reg == S_UNLOAD);
  assign frame_done = out_acc && (rd_cnt_reg == LAST);
  assign err        = (state_reg == S_ERR);

endmodule

// File: tb/tb_sort_stream_io.sv
// Bench for sort_stream_io: behavioural RAM + sort engine, scoreboard of sorted frames,
// backpressure, mid-frame resets and sorter timeout.
module tb_sort_stream_io;
  localparam int K = 8, AW = 3, DW = 8, TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sort_stream_io_if #(.DW(DW)) in_if ();
  sort_stream_io_if #(.DW(DW)) out_if ();

  logic          mem_sel, ram_we, sort_s, busy, frame_done, err;
  logic          sort_done = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  sort_stream_io #(.K(K), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_s(in_if), .out_s(out_if),
    .mem_sel(mem_sel), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .sort_s(sort_s), .sort_done(sort_done),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  int n_tests = 0, n_fail = 0;
  int words_out = 0, frames_done = 0;
  int lat = 3;
  bit hang = 1'b0;
  bit bp_mode = 1'b0;
  logic [7:0] exp_q[$];

  function automatic logic [63:0] sort8(input logic [63:0] v);
    logic [7:0] a[8];
    logic [7:0] t;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) a[i] = v[i*8 +: 8];
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // RAM with asynchronous read plus a one-shot sort engine behind the s/done handshake.
  logic [7:0]  mem[8];
  logic [63:0] mem_packed, mem_sorted;
  logic [3:0]  eng_cnt = 4'd0;
  always_comb begin
    mem_packed = '0;
    for (int k = 0; k < 8; k++) mem_packed[k*8 +: 8] = mem[k];
  end
  assign mem_sorted = sort8(mem_packed);
  assign ram_dout   = mem[ram_addr];

  always @(posedge clk) begin
    if (mem_sel && ram_we) mem[ram_addr] <= ram_din;
    if (!sort_s) begin
      eng_cnt   <= 4'd0;
      sort_done <= 1'b0;
    end else if (!sort_done && !hang) begin
      if (eng_cnt == lat[3:0]) begin
        for (int k = 0; k < 8; k++) mem[k] <= mem_sorted[k*8 +: 8];
        sort_done <= 1'b1;
      end else begin
        eng_cnt <= eng_cnt + 4'd1;
      end
    end
  end

  // Consumer: ready either always high or low for 3 cycles in front of every word.
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    out_if.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!bp_mode) begin
        out_if.ready = 1'b1;
      end else if (out_if.valid && stall_cnt < 3) begin
        out_if.ready = 1'b0;
        stall_cnt++;
      end else begin
        out_if.ready = out_if.valid;
        if (out_if.valid) stall_cnt = 0;
      end
    end
  end

  // Output monitor / scoreboard.
  initial begin
    int out_idx;
    bit stall_valid;
    logic [7:0] stall_data, exp;
    out_idx = 0; stall_valid = 1'b0; stall_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        out_idx = 0; stall_valid = 1'b0;
      end else begin
        if (out_if.valid && stall_valid) check("out_stable", out_if.data, stall_data);
        if (frame_done) check("fd_with_accept", out_if.valid && out_if.ready, 1);
        if (out_if.valid && out_if.ready) begin
          check("sb_has_entry", exp_q.size() > 0, 1);
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
          check("out_data", out_if.data, exp);
          check("frame_done_flag", frame_done, out_idx == 7);
          $display("[TB] out word %0d (idx %0d): %02h expected %02h", words_out, out_idx, out_if.data, exp);
          out_idx = (out_idx + 1) % 8;
          words_out++;
          if (frame_done) frames_done++;
          stall_valid = 1'b0;
        end else begin
          stall_valid = out_if.valid;
          stall_data  = out_if.data;
        end
      end
    end
  end

  task automatic send_frame(input logic [63:0] v, input int gap, input bit push);
    logic [63:0] s;
    int t;
    for (int i = 0; i < 8; i++) begin
      in_if.valid = 1'b1;
      in_if.data  = v[i*8 +: 8];
      t = 0;
      @(negedge clk);
      while (!in_if.ready && t < 3000) begin @(negedge clk); t++; end
      if (t >= 3000) check("in_ready_wait", t, 0);
      @(posedge clk); #1;
      if (gap > 0 && i < 7) begin
        in_if.valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    in_if.valid = 1'b0;
    if (push) begin
      s = sort8(v);
      for (int k = 0; k < 8; k++) exp_q.push_back(s[k*8 +: 8]);
    end
  endtask

  task automatic wait_frames(input int target);
    int t;
    t = 0;
    while (frames_done < target && t < 3000) begin @(posedge clk); t++; end
    check("frame_wait", frames_done >= target, 1);
    #1;
  endtask

  task automatic assert_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("mrst_in_ready", in_if.ready, 0);
    check("mrst_out_valid", out_if.valid, 0);
    check("mrst_sort_s", sort_s, 0);
    check("mrst_busy", busy, 0);
    check("mrst_mem_sel", mem_sel, 0);
    check("mrst_err", err, 0);
    exp_q.delete();
    in_if.valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("idle_in_ready", in_if.ready, 0);
    check("idle_mem_sel", mem_sel, 1);
    @(posedge clk); #1;
    check("load_in_ready", in_if.ready, 1);
  endtask

  initial begin
    int cnt;
    int base;
    in_if.valid = 1'b1;
    in_if.data  = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_if.ready, 0);
    check("rst_out_valid", out_if.valid, 0);
    check("rst_out_data", out_if.data, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_sort_s", sort_s, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err", err, 0);
    check("rst_mem_sel", mem_sel, 0);
    in_if.valid = 1'b0;
    release_reset();

    // Basic frame 5,3,7,1,0,6,2,4
    send_frame({8'd4, 8'd2, 8'd6, 8'd0, 8'd1, 8'd7, 8'd3, 8'd5}, 0, 1);
    check("in_ready_drop", in_if.ready, 0);
    check("sort_s_rise", sort_s, 1);
    check("sort_busy", busy, 1);
    check("sort_mem_sel", mem_sel, 0);
    wait_frames(1);
    check("in_ready_resume", in_if.ready, 1);
    check("busy_clear", busy, 0);

    // Input gaps with output backpressure
    bp_mode = 1'b1;
    send_frame({8'd4, 8'd2, 8'd6, 8'd0, 8'd1, 8'd7, 8'd3, 8'd5}, 1, 1);
    wait_frames(2);
    bp_mode = 1'b0;

    // Duplicates and extremes
    send_frame({8'hFF, 8'h80, 8'h01, 8'h00, 8'h80, 8'hFF, 8'h00, 8'hFF}, 0, 1);
    wait_frames(3);

    // Two back-to-back frames: 8..1 then 1..8
    send_frame({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 0, 1);
    send_frame({8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 0, 1);
    wait_frames(5);
    check("in_ready_after_pair", in_if.ready, 1);

    // Reset during SORT
    lat = 10;
    send_frame({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_sort_s", sort_s, 1);
    assert_reset();
    lat = 3;
    release_reset();
    send_frame({8'h10, 8'h30, 8'h20, 8'h50, 8'h40, 8'h70, 8'h60, 8'h05}, 0, 1);
    wait_frames(6);

    // Reset during UNLOAD after three words
    bp_mode = 1'b1;
    base = words_out;
    send_frame({8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88}, 0, 1);
    cnt = 0;
    while (words_out < base + 3 && cnt < 1000) begin @(posedge clk); cnt++; end
    check("unload_progress", words_out >= base + 3, 1);
    assert_reset();
    bp_mode = 1'b0;
    release_reset();
    send_frame({8'hC3, 8'h3C, 8'h00, 8'hFE, 8'h7F, 8'h81, 8'h18, 8'h42}, 0, 1);
    wait_frames(7);

    // Sorter never answers: watchdog
    hang = 1'b1;
    send_frame({8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4}, 0, 0);
    cnt = 0;
    while (sort_s && cnt < 100) begin cnt++; @(posedge clk); #1; end
    check("sort_s_cycles", cnt, 16);
    check("to_err", err, 1);
    check("to_sort_s", sort_s, 0);
    check("to_in_ready", in_if.ready, 0);
    check("to_out_valid", out_if.valid, 0);
    check("to_mem_sel", mem_sel, 1);
    repeat (5) @(posedge clk);
    #1;
    check("to_err_sticky", err, 1);
    check("to_in_ready_held", in_if.ready, 0);
    hang = 1'b0;
    assert_reset();
    release_reset();
    send_frame({8'd0, 8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6}, 0, 1);
    wait_frames(8);

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sort_stream_io.md
Name: sort_stream_io

Overview:
- Stream front/back end for the 8-entry RAM sort engine (datapath + controller + ram8).
- Accepts K bytes on a valid/ready input stream and writes them into the sort RAM.
- Pulses the sorter's start handshake (s/done), then reads the sorted RAM contents out on a valid/ready output stream.
- Owns the RAM port during load and unload; the top-level RAM mux selects between this block and the sort datapath via mem_sel.

Parameters:
- K, 8, number of words per frame (2..2^AW).
- AW, 3, RAM address width.
- DW, 8, data width.
- TIMEOUT, 1024, max cycles in SORT waiting for done (0 = watchdog disabled).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_data  in  DW  input word
- in_ready  out  1  block accepts input word
- out_valid  out  1  sorted word valid
- out_data  out  DW  sorted word
- out_ready  in  1  consumer accepts sorted word
- mem_sel  out  1  1 = this block drives RAM, 0 = sort datapath drives RAM
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data, combinational (asynchronous) read of ram_addr
- sort_s  out  1  start to sort controller
- sort_done  in  1  done from sort controller
- busy  out  1  high in SORT and UNLOAD
- frame_done  out  1  one-cycle pulse when last sorted word accepted
- err  out  1  sticky sort-timeout flag

Behaviour:
- Reset (rst=0, async): state=IDLE, wr_cnt=rd_cnt=0, wdog=0. All outputs 0: in_ready, out_valid, ram_we, sort_s, busy, frame_done, err, ram_addr, ram_din, out_data, mem_sel.
- All outputs are decoded from registered state/counters; there is no combinational path from in_valid/out_ready to in_ready/out_valid.
- IDLE: mem_sel=1. Next cycle goes to LOAD unconditionally (one dead cycle after reset release).
- LOAD: mem_sel=1, in_ready=1.
  - ram_we = in_valid; ram_addr = wr_cnt; ram_din = in_data.
  - Each cycle with in_valid&in_ready: write lands that edge, wr_cnt++.
  - On accept with wr_cnt==K-1: wr_cnt<=0 and go to SORT. in_ready drops the next cycle.
  - Gaps in in_valid: no write, counter holds.
- SORT: mem_sel=0, sort_s=1, busy=1, ram_we=0, wdog increments every cycle.
  - sort_done=1: go to UNLOAD and clear wdog. sort_s falls the same edge, so the sort controller sees s low and returns to its idle state.
  - sort_done already high on SORT entry: treated identically (one-cycle SORT).
  - TIMEOUT!=0 and wdog==TIMEOUT-1 without done: err<=1, sort_s<=0, go to ERR.
  - sort_done and timeout in the same cycle: done wins.
- UNLOAD: mem_sel=1, busy=1, ram_we=0.
  - ram_addr = rd_cnt; out_valid=1; out_data = ram_dout, which is therefore stable while stalled.
  - out_valid&out_ready: rd_cnt++.
  - Accept with rd_cnt==K-1: frame_done=1 for that cycle, rd_cnt<=0, go to LOAD.
  - out_valid never drops without acceptance.
- ERR: all handshake outputs 0, mem_sel=1, err=1. Held until reset.
- Order: the output is exactly the RAM contents at addresses 0..K-1 after sorting. This block does no comparison itself.
- Back-to-back frames: LOAD resumes the cycle after frame_done. No input is accepted during SORT/UNLOAD.
- Reset mid-frame (any state): immediate return to IDLE. Partial frame discarded, sort_s low asynchronously.
- Counters are AW+1 bits internally to avoid wrap when K==2^AW.

Test Plan:
- Basic frame: input 5,3,7,1,0,6,2,4 back-to-back with real sort engine, out_ready=1 -> in_ready drops after 8th accept; sort_s high next cycle until done; output 0,1,2,3,4,5,6,7; frame_done pulses with word 7; in_ready=1 next cycle.
- Input gaps and output backpressure: in_valid toggling 1/0; out_ready low 3 cycles on every word -> same sorted 8 words; out_data stable while stalled; no duplicate or lost words.
- Duplicates/extremes: 0xFF,0x00,0xFF,0x80,0x00,0x01,0x80,0xFF -> 00,00,01,80,80,FF,FF,FF.
- Timeout: sort_done tied 0, TIMEOUT=16 -> sort_s high exactly 16 cycles, then err=1, sort_s=0, in_ready=0 until reset.
- Reset mid-SORT and mid-UNLOAD: assert rst low -> all outputs 0 immediately; after release, 1 IDLE cycle, then in_ready=1 and a fresh frame sorts correctly.
- Two consecutive frames (8..1 then 1..8 reversed) -> two ascending streams, two frame_done pulses, no cross-frame corruption.
